// File: rtl/mtimer_bank.sv
// mtimer_bank: memory-mapped machine timer with NUM_CMP compare channels.
//
// Provides a 64-bit mtime counter advanced by a programmable prescaler,
// NUM_CMP mtimecmp registers driving level timer interrupts, per-channel
// software-interrupt bits (msip), and a hi-word snapshot that makes a
// lo-then-hi read of mtime atomic.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req_i       bus access valid this cycle
//   we_i        1 = store, 0 = load
//   be_i        store byte enables
//   addr_i      byte address
//   wdata_i     store data
//   rdata_o     registered load data, held while rvalid_o is low
//   rvalid_o    pulses one cycle after a load request
//   err_o       pulses one cycle after a misaligned/unmapped access
//   tmr_irq_o   per-channel mtime >= mtimecmp, registered
//   sw_irq_o    per-channel msip bits, registered
//   mtime_o     current mtime
module mtimer_bank #(
  parameter int unsigned NUM_CMP   = 2,
  parameter int unsigned PRESC_W   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               rvalid_o,
  output logic               err_o,
  output logic [NUM_CMP-1:0] tmr_irq_o,
  output logic [NUM_CMP-1:0] sw_irq_o,
  output logic [63:0]        mtime_o
);

  localparam int unsigned NumWords = 4 + 2 * NUM_CMP;

  logic [63:0]        mtime_q, mtime_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [NUM_CMP-1:0] msip_q, msip_d;
  logic [31:0]        snap_q, snap_d;
  logic [63:0]        cmp_q [NUM_CMP];
  logic [63:0]        cmp_d [NUM_CMP];
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic [NUM_CMP-1:0] tmr_irq_q, tmr_irq_d;
  logic [NUM_CMP-1:0] sw_irq_q, sw_irq_d;

  logic        sel, acc_ok, wr, rd, tick, mt_wr;
  logic [5:0]  word;
  logic [31:0] bmask, rd_word;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [31:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  assign sel    = req_i && (addr_i[31:8] == BASE_ADDR[31:8]);
  assign word   = addr_i[7:2];
  assign acc_ok = sel && (addr_i[1:0] == 2'b00) && (32'(word) < NumWords);
  assign wr     = acc_ok && we_i;
  assign rd     = acc_ok && !we_i;
  assign bmask  = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign tick   = (cnt_q == presc_q);

  always_comb begin
    mtime_d  = mtime_q;
    presc_d  = presc_q;
    msip_d   = msip_q;
    snap_d   = snap_q;
    cmp_d    = cmp_q;
    rdata_d  = rdata_q;
    rd_word  = '0;
    mt_wr    = 1'b0;
    cnt_d    = tick ? '0 : cnt_q + PRESC_W'(1);

    if (wr) begin
      case (word)
        6'd0: begin
          mtime_d[31:0] = merge(mtime_q[31:0], wdata_i, bmask);
          mt_wr         = 1'b1;
        end
        6'd1: begin
          mtime_d[63:32] = merge(mtime_q[63:32], wdata_i, bmask);
          mt_wr          = 1'b1;
        end
        6'd2: begin
          presc_d = PRESC_W'(merge(32'(presc_q), wdata_i, bmask));
          cnt_d   = '0;
        end
        6'd3: msip_d = NUM_CMP'(merge(32'(msip_q), wdata_i, bmask));
        default: begin
          for (int i = 0; i < NUM_CMP; i++) begin
            if (word == 6'(4 + 2 * i)) cmp_d[i][31:0]  = merge(cmp_q[i][31:0], wdata_i, bmask);
            if (word == 6'(5 + 2 * i)) cmp_d[i][63:32] = merge(cmp_q[i][63:32], wdata_i, bmask);
          end
        end
      endcase
    end

    // A store to either mtime half suppresses the whole increment.
    if (!mt_wr && tick) mtime_d = mtime_q + 64'd1;

    if (rd) begin
      case (word)
        6'd0: begin
          rd_word = mtime_q[31:0];
          snap_d  = mtime_q[63:32];
        end
        6'd1: rd_word = snap_q;
        6'd2: rd_word = 32'(presc_q);
        6'd3: rd_word = 32'(msip_q);
        default: begin
          for (int i = 0; i < NUM_CMP; i++) begin
            if (word == 6'(4 + 2 * i)) rd_word = cmp_q[i][31:0];
            if (word == 6'(5 + 2 * i)) rd_word = cmp_q[i][63:32];
          end
        end
      endcase
    end

    // Faulting loads return zero; stores leave rdata untouched.
    if (sel && !we_i) rdata_d = rd_word;
    rvalid_d = sel && !we_i;
    err_d    = sel && !acc_ok;

    for (int i = 0; i < NUM_CMP; i++) tmr_irq_d[i] = (mtime_d >= cmp_d[i]);
    sw_irq_d = msip_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q   <= '0;
      presc_q   <= '0;
      cnt_q     <= '0;
      msip_q    <= '0;
      snap_q    <= '0;
      for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= '1;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      tmr_irq_q <= '0;
      sw_irq_q  <= '0;
    end else begin
      mtime_q   <= mtime_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      msip_q    <= msip_d;
      snap_q    <= snap_d;
      cmp_q     <= cmp_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      tmr_irq_q <= tmr_irq_d;
      sw_irq_q  <= sw_irq_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign err_o     = err_q;
  assign tmr_irq_o = tmr_irq_q;
  assign sw_irq_o  = sw_irq_q;
  assign mtime_o   = mtime_q;

endmodule

// File: doc/mtimer_bank.md
Name: mtimer_bank

Overview:
- Parametrised successor to the core's built-in mtime/mtimecmp register pair.
- Memory-mapped machine timer with NUM_CMP independent compare channels, a programmable prescaler, per-channel software-interrupt bits, and a race-free 64-bit read through a hi-word snapshot.
- Sits on the data bus beside data memory. The core routes accesses in the BASE_ADDR window here and receives rdata and the interrupt lines.

Parameters:
- NUM_CMP, 2, number of mtimecmp channels (1..8).
- PRESC_W, 16, width of the prescaler reload register.
- BASE_ADDR, 32'h0200_0000, base of the 256-byte register window.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_i  in  1  bus access valid this cycle
- we_i  in  1  1 = store, 0 = load
- be_i  in  4  byte enables for stores
- addr_i  in  32  byte address
- wdata_i  in  32  store data
- rdata_o  out  32  load data, registered
- rvalid_o  out  1  load data valid; pulses one cycle after a load req
- err_o  out  1  pulses one cycle after any req to an unmapped or misaligned address
- tmr_irq_o  out  NUM_CMP  per-channel timer interrupt, level
- sw_irq_o  out  NUM_CMP  per-channel software interrupt, level
- mtime_o  out  64  current mtime, for debug/CSR time shadow

Behaviour:
- Clock and reset: clk is the clock; rst is synchronous, active-high.
- Register map (offsets from BASE_ADDR):
  - 0x00 mtime_lo; 0x04 mtime_hi.
  - 0x08 prescale (PRESC_W LSBs, upper bits read 0).
  - 0x0C msip (NUM_CMP LSBs).
  - 0x10+8*i mtimecmp_i lo; 0x14+8*i mtimecmp_i hi.
  - Every other offset in the window is unmapped.
- Selection: an access is selected when req_i=1 and addr_i[31:8]==BASE_ADDR[31:8].
  - addr_i[1:0]!=0 → misaligned: no write, err_o=1 next cycle, rvalid_o=1 with rdata 0 if load.
  - Unmapped offset → same as misaligned.
- Reset values:
  - mtime=0, prescale=0, presc_cnt=0, msip=0, snapshot=0.
  - All mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
  - rdata_o=0, rvalid_o=0, err_o=0, tmr_irq_o=0, sw_irq_o=0.
  - A reset asserted mid-access discards the access; no rvalid_o follows.
- Prescaler:
  - presc_cnt counts up each cycle. When presc_cnt==prescale, presc_cnt←0 and tick=1; otherwise tick=0.
  - prescale=0 gives a tick every cycle.
  - Writing prescale resets presc_cnt to 0 in the same cycle.
- mtime:
  - On tick, mtime←mtime+1 as 64-bit, with carry into the hi word; wraps from 2^64-1 to 0.
- Stores:
  - Each byte lane updates only if its be_i bit is set.
  - A store to mtime_lo or mtime_hi in a tick cycle: the written word takes the store data; the increment is suppressed for the whole of mtime that cycle (no carry into the unwritten half).
  - be_i bits beyond a register's width are ignored.
- Loads:
  - Latency 1: rdata_o/rvalid_o are registered from the request cycle's state.
  - A load of mtime_lo also copies the current mtime[63:32] into snapshot.
  - A load of mtime_hi returns snapshot, not live mtime_hi. The lo-then-hi read sequence is therefore atomic.
  - Stores never assert rvalid_o.
  - rdata_o holds its value when rvalid_o=0.
- Interrupts (registered, so they update the cycle after a state change):
  - tmr_irq_o[i] = (mtime >= mtimecmp_i), 64-bit unsigned compare on the post-update mtime.
  - sw_irq_o = msip.
  - A store to a mtimecmp word is visible on tmr_irq_o one cycle later. A glitch during a two-word update is permitted; software writes hi=all-ones first.
- Back-to-back: req_i may be asserted every cycle. There is no backpressure; every selected req completes in one cycle.

Test Plan:
- Reset, then run 10 cycles with prescale=0 → mtime_o=10, all tmr_irq_o=0, rvalid_o never high.
- Store 0x3 to prescale, then run 16 cycles → mtime advances by exactly 4. The store cycle restarts presc_cnt.
- Store mtime_lo=0xFFFF_FFFE, mtime_hi=0, prescale=0, then load lo in the cycle mtime_lo=0xFFFF_FFFF. Wait 3 cycles, then load hi → rdata_o lo=0xFFFF_FFFF then hi=0 from the snapshot, while live mtime_o[63:32]=1.
- Store mtimecmp_1 hi=0 then lo=20 with mtime=15 and prescale=0 → tmr_irq_o[1] rises on the cycle after mtime reaches 20; tmr_irq_o[0] stays 0. Then store mtimecmp_1 hi=0xFFFF_FFFF → irq clears one cycle later.
- Store to mtime_lo with be_i=4'b0011, wdata=0xAAAA_5555, in a tick cycle, with mtime=0x1234_0000 → mtime_lo=0x1234_5555, no increment that cycle.
- Load at BASE_ADDR+0x02 and at BASE_ADDR+0xFC (NUM_CMP=2) → err_o=1 and rvalid_o=1 with rdata_o=0 the next cycle, no state change. Assert rst during a load req → rvalid_o stays 0.
